alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream issue stage for the combinational 32-bit ALU (A,B,S[2:0],C_in -> F,Cout,overflow).
//  Buffers operand/opcode commands in a FIFO, drives one command at a time onto the ALU
//  input bus, and registers F/Cout/overflow into a valid/ready result port.
//  Keeps a saturating count of results that raised overflow.
// PARAMETERS
//  WIDTH   32  operand/result width; must match the ALU instance
//  DEPTH   4   command FIFO entries; power of 2, >= 2
//  ADDR_W  2   log2(DEPTH)
// PORTS
//  clk        in   1        single clock; all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        FIFO can accept; push = cmd_valid & cmd_ready
//  cmd_a      in   WIDTH    operand A
//  cmd_b      in   WIDTH    operand B
//  cmd_s      in   3        ALU function select
//  cmd_cin    in   1        ALU carry-in
//  alu_a      out  WIDTH    to ALU A
//  alu_b      out  WIDTH    to ALU B
//  alu_s      out  3        to ALU S
//  alu_cin    out  1        to ALU C_in
//  alu_f      in   WIDTH    from ALU F
//  alu_cout   in   1        from ALU Cout
//  alu_ovf    in   1        from ALU overflow
//  res_valid  out  1        result held
//  res_ready  in   1        consumer takes result; pop = res_valid & res_ready
//  res_f      out  WIDTH    registered F
//  res_cout   out  1        registered Cout
//  res_ovf    out  1        registered overflow
//  count      out  ADDR_W+1 FIFO occupancy, 0..DEPTH
//  busy       out  1        state != IDLE
//  ovf_cnt    out  8        overflow results delivered, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, including cmd_ready. FIFO pointers and count 0; state IDLE.
//   cmd_ready goes to 1 in the first cycle after rst deasserts.
//  Reset mid-operation: queued commands, operands and any pending result are discarded.
//   No result is emitted for them after reset.
//  FIFO: cmd_ready = (count != DEPTH), from registered count.
//   No push when full, even if the FIFO pops in the same cycle.
//   Pointers ADDR_W bits, wrap DEPTH-1 -> 0. Simultaneous push and pop leaves count unchanged.
//   No bypass: a command pushed into an empty FIFO pops no earlier than the next edge.
//  FSM states: IDLE, DRIVE, HOLD.
//   IDLE: if count != 0, pop head into alu_a/b/s/cin registers -> DRIVE.
//   DRIVE: ALU inputs stable for one full cycle. At edge, capture alu_f/cout/ovf into res_*,
//    set res_valid=1 -> HOLD.
//   HOLD: res_* and alu_* stay stable while res_ready=0.
//    On pop: res_valid=0. If count != 0, pop next head into alu_* -> DRIVE, else -> IDLE.
//  Latency: command accepted at edge k -> popped at edge k+1 -> res_valid=1 after edge k+2.
//  Throughput: one result per 2 cycles with res_ready held at 1.
//  alu_* outputs keep the last driven command while IDLE; they are 0 only after reset.
//  ovf_cnt: +1 at the DRIVE->HOLD capture edge when alu_ovf=1. Holds at 255; cleared only by rst.
//  Results leave in command order. The block never alters the ALU data path.
// TESTING (bench instantiates the team ALU; S=3 is A+B+C_in)
//  1. A=16,B=8,S=3,cin=0, res_ready=1 -> res_valid 2 cycles after accept; F=24, Cout=0, ovf=0.
//  2. res_ready=0, push 6 cmds -> 5 accepted (1 in alu_* regs, count=4), cmd_ready=0 on 6th.
//     Then res_ready=1 -> 5 results in order, count reaches 0.
//  3. A=32'h7FFFFFFF,B=1,S=3 -> res_f=32'h80000000, res_ovf=1, ovf_cnt 0->1.
//  4. Hold res_ready=0 for 5 cycles with result pending -> res_* and alu_* unchanged, count unchanged.
//  5. 3 cmds queued, one in HOLD; rst for 1 cycle -> all outputs 0, count=0; no stale result after.
//  6. 260 overflowing ops -> ovf_cnt stops at 255.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of a combinational ALU: queues commands, drives one at a time onto the
// ALU input bus and registers the ALU result into a valid/ready port.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic [2:0]        cmd_s,
    input  logic              cmd_cin,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [2:0]        alu_s,
    output logic              alu_cin,
    input  logic [WIDTH-1:0]  alu_f,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_f,
    output logic              res_cout,
    output logic              res_ovf,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic [7:0]        ovf_cnt
);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    localparam logic [ADDR_W:0] Full = (ADDR_W + 1)'(DEPTH);

    state_e state_q;

    logic [WIDTH-1:0]  fifo_a   [DEPTH];
    logic [WIDTH-1:0]  fifo_b   [DEPTH];
    logic [2:0]        fifo_s   [DEPTH];
    logic              fifo_cin [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              push;
    logic              pop;

    assign push  = cmd_valid && cmd_ready;
    assign count = count_q;
    assign busy  = (state_q != StIdle);

    // A pop only ever loads the ALU input registers, so it happens from IDLE or on result handoff.
    always_comb begin
        pop = 1'b0;
        if (count_q != '0) begin
            unique case (state_q)
                StIdle:  pop = 1'b1;
                StHold:  pop = res_ready;
                default: pop = 1'b0;
            endcase
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible through the reset pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr_q]   <= cmd_a;
            fifo_b[wr_ptr_q]   <= cmd_b;
            fifo_s[wr_ptr_q]   <= cmd_s;
            fifo_cin[wr_ptr_q] <= cmd_cin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cmd_ready <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_f     <= '0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            count_q   <= count_d;
            // Tracks the next count so cmd_ready equals (count != DEPTH) yet stays 0 in reset.
            cmd_ready <= (count_d != Full);

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                alu_a    <= fifo_a[rd_ptr_q];
                alu_b    <= fifo_b[rd_ptr_q];
                alu_s    <= fifo_s[rd_ptr_q];
                alu_cin  <= fifo_cin[rd_ptr_q];
            end

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    res_f     <= alu_f;
                    res_cout  <= alu_cout;
                    res_ovf   <= alu_ovf;
                    res_valid <= 1'b1;
                    if (alu_ovf && (ovf_cnt != 8'hFF)) begin
                        ovf_cnt <= ovf_cnt + 8'd1;
                    end
                    state_q <= StHold;
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= pop ? StDrive : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU on the alu_* bus and a result scoreboard.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_s;
    logic        cmd_cin;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_s;
    logic        alu_cin;
    logic [31:0] alu_f;
    logic        alu_cout;
    logic        alu_ovf;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_f;
    logic        res_cout;
    logic        res_ovf;
    logic [2:0]  count;
    logic        busy;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int failures = 0;
    int n_results = 0;
    int exp_ovf = 0;
    logic [33:0] sb[$];

    alu_op_sequencer #(
        .WIDTH  (32),
        .DEPTH  (4),
        .ADDR_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_s     (cmd_s),
        .cmd_cin   (cmd_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_cin   (alu_cin),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout),
        .alu_ovf   (alu_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .count     (count),
        .busy      (busy),
        .ovf_cnt   (ovf_cnt)
    );

    // Behavioural ALU: returns {overflow, cout, f}; S=3 is A+B+C_in.
    function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] s, input logic cin);
        logic [32:0] sum;
        logic [31:0] f;
        logic        co;
        logic        ov;
        co = 1'b0;
        ov = 1'b0;
        case (s)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: begin
                sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                f   = sum[31:0];
                co  = sum[32];
                ov  = (a[31] == b[31]) && (f[31] != a[31]);
            end
            3'd4: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                f   = sum[31:0];
                co  = sum[32];
                ov  = (a[31] != b[31]) && (f[31] != a[31]);
            end
            default: f = ~(a | b);
        endcase
        return {ov, co, f};
    endfunction

    assign {alu_ovf, alu_cout, alu_f} = alu_model(alu_a, alu_b, alu_s, alu_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expectations enter on accept and are compared on result handoff.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst) begin
            sb.delete();
            exp_ovf = 0;
        end else begin
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_result got f=%h required no result", res_f);
                end else begin
                    e = sb.pop_front();
                    if ({res_ovf, res_cout, res_f} !== e) begin
                        failures++;
                        $display("FAIL sb_result got={%b,%b,%h} required={%b,%b,%h}",
                                 res_ovf, res_cout, res_f, e[33], e[32], e[31:0]);
                    end
                end
                n_results++;
            end
            if (cmd_valid && cmd_ready) begin
                e = alu_model(cmd_a, cmd_b, cmd_s, cmd_cin);
                sb.push_back(e);
                if (e[33] && exp_ovf < 255) exp_ovf++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                           input logic cin);
        cmd_a     = a;
        cmd_b     = b;
        cmd_s     = s;
        cmd_cin   = cin;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_drain(output bit timed_out);
        int cyc = 0;
        while ((count != 3'd0 || busy || res_valid) && cyc < 200) begin
            tick();
            cyc++;
        end
        timed_out = (cyc >= 200);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        set_cmd(32'd0, 32'd0, 3'd0, 1'b0);
        cmd_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if ({cmd_ready, res_valid, busy, count, ovf_cnt, alu_a, res_f} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b val=%b busy=%b cnt=%0d ovf=%0d a=%h f=%h required all 0",
                     cmd_ready, res_valid, busy, count, ovf_cnt, alu_a, res_f);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b required=1", cmd_ready);
        end
    endtask

    task automatic test_single();
        bit to;
        res_ready = 1'b1;
        set_cmd(32'd16, 32'd8, 3'd3, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 32'd16 || alu_b !== 32'd8) begin
            failures++;
            $display("FAIL single_drive got val=%b busy=%b a=%0d b=%0d required val=0 busy=1 a=16 b=8",
                     res_valid, busy, alu_a, alu_b);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_f !== 32'd24 || res_cout !== 1'b0 || res_ovf !== 1'b0) begin
            failures++;
            $display("FAIL single_result got val=%b f=%0d c=%b o=%b required val=1 f=24 c=0 o=0",
                     res_valid, res_f, res_cout, res_ovf);
        end
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL single_drain got timeout required idle");
        end
    endtask

    task automatic test_fill();
        bit to;
        int r0;
        r0 = n_results;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_cmd(32'(i * 100 + 1), 32'(i + 7), 3'(i % 4), 1'(i % 2));
            checks++;
            if (cmd_ready !== (i < 5)) begin
                failures++;
                $display("FAIL fill_ready_%0d got=%b required=%b", i, cmd_ready, (i < 5));
            end
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (count !== 3'd4 || res_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_full got cnt=%0d val=%b busy=%b required cnt=4 val=1 busy=1",
                     count, res_valid, busy);
        end
        res_ready = 1'b1;
        wait_drain(to);
        checks++;
        if (to || (n_results - r0) != 5) begin
            failures++;
            $display("FAIL fill_drain got results=%0d timeout=%b required results=5 timeout=0",
                     n_results - r0, to);
        end
    endtask

    task automatic test_overflow();
        bit to;
        res_ready = 1'b1;
        set_cmd(32'h7FFF_FFFF, 32'd1, 3'd3, 1'b0);
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (res_valid !== 1'b1 || res_f !== 32'h8000_0000 || res_ovf !== 1'b1 || res_cout !== 1'b0)
        begin
            failures++;
            $display("FAIL ovf_result got val=%b f=%h o=%b c=%b required val=1 f=80000000 o=1 c=0",
                     res_valid, res_f, res_ovf, res_cout);
        end
        checks++;
        if (ovf_cnt !== 8'd1) begin
            failures++;
            $display("FAIL ovf_cnt_first got=%0d required=1", ovf_cnt);
        end
        wait_drain(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL ovf_drain got timeout required idle");
        end
    endtask

    task automatic test_hold();
        bit to;
        res_ready = 1'b0;
        set_cmd(32'd5, 32'd9, 3'd3, 1'b1);
        tick();
        set_cmd(32'd100, 32'd200, 3'd3, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_f !== 32'd15 || alu_a !== 32'd5 || alu_b !== 32'd9 ||
                alu_s !== 3'd3 || alu_cin !== 1'b1 || count !== 3'd1) begin
                failures++;
                $display("FAIL hold_stable_%0d got val=%b f=%0d a=%0d b=%0d s=%0d cin=%b cnt=%0d required 1,15,5,9,3,1,1",
                         i, res_valid, res_f, alu_a, alu_b, alu_s, alu_cin, count);
            end
            tick();
        end
        res_ready = 1'b1;
        wait_drain(to);
        checks++;
        if (to || alu_a !== 32'd100) begin
            failures++;
            $display("FAIL hold_drain got timeout=%b last_a=%0d required timeout=0 last_a=100",
                     to, alu_a);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_cmd(32'h7FFF_FFFF, 32'd1, 3'd3, 1'b0);
            else set_cmd(32'(i * 3), 32'(i), 3'd3, 1'b0);
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || res_valid !== 1'b1 || ovf_cnt !== 8'(exp_ovf)) begin
            failures++;
            $display("FAIL rstmid_pre got cnt=%0d val=%b ovf=%0d required cnt=3 val=1 ovf=%0d",
                     count, res_valid, ovf_cnt, exp_ovf);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, alu_a, alu_b, alu_s, alu_cin, res_valid, res_f, res_cout, res_ovf, count,
             busy, ovf_cnt} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got rdy=%b a=%h b=%h s=%0d val=%b f=%h cnt=%0d busy=%b ovf=%0d required all 0",
                     cmd_ready, alu_a, alu_b, alu_s, res_valid, res_f, count, busy, ovf_cnt);
        end
        rst = 1'b0;
        res_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (res_valid || busy || count != 3'd0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rstmid_stale got activity=1 required activity=0");
        end
    endtask

    task automatic test_saturate();
        bit to;
        bit acc;
        int n = 0;
        int cyc = 0;
        res_ready = 1'b1;
        while (n < 260 && cyc < 3000) begin
            set_cmd(32'h7FFF_FFFF, 32'(n + 1), 3'd3, 1'b0);
            acc = cmd_ready;
            tick();
            if (acc) n++;
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n != 260) begin
            failures++;
            $display("FAIL sat_issue got accepted=%0d required=260", n);
        end
        wait_drain(to);
        checks++;
        if (to || ovf_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_ovf_cnt got=%0d timeout=%b required=255 timeout=0", ovf_cnt, to);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sat_sb_empty got pending=%0d required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
